// File: rtl/bullet_slot_arbiter.sv
// Bullet slot arbiter: one round-robin grant per cycle, lowest free slot allocated, slots returned by release.
// Optional macro PLAYER_PRIORITY_EN gives requester 0 (player) absolute priority over the enemy ports.
module bullet_slot_arbiter #(
  parameter int N_REQ   = 4,
  parameter int N_SLOTS = 10,
  parameter int SLOT_W  = 4,
  parameter int CNT_W   = 5
) (
  input  logic               clk_100mhz,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic               release_valid,
  input  logic [SLOT_W-1:0]  release_slot,
  output logic [N_REQ-1:0]   grant,
  output logic               grant_valid,
  output logic [SLOT_W-1:0]  grant_slot,
  output logic [N_SLOTS-1:0] slot_busy,
  output logic [CNT_W-1:0]   n_busy,
  output logic               full,
  output logic               err_release
);

  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [RR_W-1:0]    rr_ptr_r;
  logic [N_REQ-1:0]   eligible_s;
  logic [RR_W-1:0]    win_idx_s;
  logic [RR_W-1:0]    rr_next_s;
  logic               win_found_s;
  logic [SLOT_W-1:0]  free_idx_s;
  logic               free_found_s;
  logic               do_alloc_s;
  logic [N_SLOTS-1:0] alloc_mask_s;
  logic [N_SLOTS-1:0] rel_mask_s;
  logic               rel_ok_s;
  logic               rel_bad_s;
  logic [N_SLOTS-1:0] busy_next_s;
  logic [CNT_W-1:0]   n_busy_next_s;

  // Winner selection: scan from rr_ptr downwards in priority so the nearest eligible index is kept.
  always_comb begin
    eligible_s  = req & ~grant;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      win_found_s = win_found_s | eligible_s[(int'(rr_ptr_r) + k) % N_REQ];
      win_idx_s   = eligible_s[(int'(rr_ptr_r) + k) % N_REQ] ?
                    RR_W'((int'(rr_ptr_r) + k) % N_REQ) : win_idx_s;
    end
    rr_next_s = RR_W'((int'(win_idx_s) + 1) % N_REQ);
`ifdef PLAYER_PRIORITY_EN
    // Player overrides the enemy rotation and leaves the pointer where it was.
    if (eligible_s[0]) begin
      win_found_s = 1'b1;
      win_idx_s   = '0;
      rr_next_s   = rr_ptr_r;
    end else begin
      rr_next_s   = RR_W'((int'(win_idx_s) + 1) % N_REQ);
    end
`endif
  end

  // Lowest free slot and the release decode, both judged on the pre-release bitmap.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    rel_mask_s   = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      free_found_s  = free_found_s | ~slot_busy[i];
      free_idx_s    = slot_busy[i] ? free_idx_s : SLOT_W'(i);
      rel_mask_s[i] = release_valid && (release_slot == SLOT_W'(i)) && slot_busy[i];
    end
    rel_ok_s      = |rel_mask_s;
    rel_bad_s     = release_valid & ~rel_ok_s;
    do_alloc_s    = win_found_s & free_found_s;
    alloc_mask_s  = do_alloc_s ? (N_SLOTS'(1) << free_idx_s) : '0;
    busy_next_s   = (slot_busy & ~rel_mask_s) | alloc_mask_s;
    n_busy_next_s = n_busy + CNT_W'(do_alloc_s) - CNT_W'(rel_ok_s);
  end

  // Registered outputs, pointer and bitmap.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_slot  <= '0;
      slot_busy   <= '0;
      n_busy      <= '0;
      full        <= 1'b0;
      err_release <= 1'b0;
      rr_ptr_r    <= '0;
    end else begin
      grant       <= do_alloc_s ? (N_REQ'(1) << win_idx_s) : '0;
      grant_valid <= do_alloc_s;
      if (do_alloc_s) begin
        grant_slot <= free_idx_s;
        rr_ptr_r   <= rr_next_s;
      end
      slot_busy   <= busy_next_s;
      n_busy      <= n_busy_next_s;
      full        <= (n_busy_next_s == CNT_W'(N_SLOTS));
      err_release <= err_release | rel_bad_s;
    end
  end

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Self-checking bench for bullet_slot_arbiter: directed vector table, async reset sequence, random run vs model.
module tb_bullet_slot_arbiter;
  localparam int N_REQ = 4, N_SLOTS = 10, SLOT_W = 4, CNT_W = 5;

  logic               clk_100mhz = 1'b0;
  logic               rst = 1'b0;
  logic [N_REQ-1:0]   req = '0;
  logic               release_valid = 1'b0;
  logic [SLOT_W-1:0]  release_slot = '0;
  logic [N_REQ-1:0]   grant;
  logic               grant_valid;
  logic [SLOT_W-1:0]  grant_slot;
  logic [N_SLOTS-1:0] slot_busy;
  logic [CNT_W-1:0]   n_busy;
  logic               full;
  logic               err_release;

  bullet_slot_arbiter #(.N_REQ(N_REQ), .N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W), .CNT_W(CNT_W)) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .req(req), .release_valid(release_valid),
    .release_slot(release_slot), .grant(grant), .grant_valid(grant_valid),
    .grant_slot(grant_slot), .slot_busy(slot_busy), .n_busy(n_busy), .full(full),
    .err_release(err_release));

  always #5 clk_100mhz = ~clk_100mhz;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: table of busy flags, last winner, pointer, sticky error.
  bit m_busy [N_SLOTS];
  int m_gidx;
  int m_gslot;
  int m_rr;
  bit m_err;

  typedef struct {
    bit         do_rst;
    logic [3:0] rq;
    bit         rv;
    int         rs;
    logic [3:0] g;
    int         gs;
    logic [9:0] busy;
    int         nb;
    bit         err;
  } vec_t;
  vec_t vt[$];

  function automatic void add(bit d, logic [3:0] rq, bit rv, int rs, logic [3:0] g, int gs,
                              logic [9:0] busy, int nb, bit err);
    vt.push_back('{d, rq, rv, rs, g, gs, busy, nb, err});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_SLOTS; i++) m_busy[i] = 1'b0;
    m_gidx = -1; m_gslot = 0; m_rr = 0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input bit rv, input int rs);
    int win, slot, j;
    bit rel_good;
    win = -1; slot = -1;
    rel_good = 1'b0;
    if (rv && rs < N_SLOTS) rel_good = m_busy[rs];
    for (int i = 0; i < N_SLOTS; i++)
      if (slot < 0 && !m_busy[i]) slot = i;
`ifdef PLAYER_PRIORITY_EN
    if (r[0] && m_gidx != 0) win = 0;
`endif
    for (int k = 0; k < N_REQ; k++) begin
      j = (m_rr + k) % N_REQ;
      if (win < 0 && r[j] && j != m_gidx) win = j;
    end
    if (win >= 0 && slot >= 0) begin
      m_busy[slot] = 1'b1;
      m_gslot = slot;
      m_gidx = win;
`ifdef PLAYER_PRIORITY_EN
      if (win != 0) m_rr = (win + 1) % N_REQ;
`else
      m_rr = (win + 1) % N_REQ;
`endif
    end else begin
      m_gidx = -1;
    end
    if (rv) begin
      if (rel_good) m_busy[rs] = 1'b0;
      else m_err = 1'b1;
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    logic [9:0] eb;
    int cnt;
    eg = (m_gidx >= 0) ? 4'(1 << m_gidx) : 4'b0;
    cnt = 0;
    for (int i = 0; i < N_SLOTS; i++) begin
      eb[i] = m_busy[i];
      cnt += int'(m_busy[i]);
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_valid", 32'(grant_valid), 32'(m_gidx >= 0));
    chk("grant_slot", 32'(grant_slot), 32'(m_gslot));
    chk("slot_busy", 32'(slot_busy), 32'(eb));
    chk("n_busy", 32'(n_busy), 32'(cnt));
    chk("full", 32'(full), 32'(cnt == N_SLOTS));
    chk("err_release", 32'(err_release), 32'(m_err));
  endtask

  task automatic step(input logic [3:0] r, input bit rv, input int rs);
    req = r;
    release_valid = rv;
    release_slot = 4'(rs);
    model_step(r, rv, rs);
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    check_model();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_gvalid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_gslot"}, 32'(grant_slot), 32'd0);
    chk({tag, "_busy"}, 32'(slot_busy), 32'd0);
    chk({tag, "_nbusy"}, 32'(n_busy), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_err"}, 32'(err_release), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_100mhz);
    req = '0; release_valid = 1'b0; release_slot = '0;
    rst = 1'b1;
    #2;
    check_zero("rst");
    @(negedge clk_100mhz);
    rst = 1'b0;
    model_reset();
    #2;
  endtask

  initial begin
    logic [3:0] pend;
    int busy_list[$];
    int rs;
    bit rv;

`ifndef PLAYER_PRIORITY_EN
    add(1'b1, 4'b0001, 1'b0, 0, 4'b0001, 0, 10'h001, 1, 1'b0);
    add(1'b0, 4'b0001, 1'b0, 0, 4'b0000, 0, 10'h001, 1, 1'b0);
    add(1'b0, 4'b0000, 1'b1, 0, 4'b0000, 0, 10'h000, 0, 1'b0);
    for (int k = 1; k <= 10; k++)
      add(k == 1, 4'b1111, 1'b0, 0, 4'(1 << ((k - 1) % 4)), k - 1, 10'((1 << k) - 1), k, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0000, 9, 10'h3FF, 10, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0000, 9, 10'h3FF, 10, 1'b0);
    add(1'b0, 4'b0010, 1'b1, 4, 4'b0000, 9, 10'h3EF, 9, 1'b0);
    add(1'b0, 4'b0010, 1'b0, 0, 4'b0010, 4, 10'h3FF, 10, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 0, 4'b0000, 4, 10'h3FF, 10, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 0, 4'b0001, 0, 10'h001, 1, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0010, 1, 10'h003, 2, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0100, 2, 10'h007, 3, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b1000, 3, 10'h00F, 4, 1'b0);
    add(1'b0, 4'b0100, 1'b1, 2, 4'b0100, 4, 10'h01B, 4, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 0, 4'b0000, 4, 10'h01B, 4, 1'b0);
    add(1'b0, 4'b0000, 1'b1, 7, 4'b0000, 4, 10'h01B, 4, 1'b1);
    add(1'b0, 4'b0000, 1'b1, 12, 4'b0000, 4, 10'h01B, 4, 1'b1);
`else
    add(1'b1, 4'b0010, 1'b0, 0, 4'b0010, 0, 10'h001, 1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 0, 4'b0000, 0, 10'h001, 1, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0001, 1, 10'h003, 2, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0100, 2, 10'h007, 3, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0001, 3, 10'h00F, 4, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b1000, 4, 10'h01F, 5, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0001, 5, 10'h03F, 6, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0010, 6, 10'h07F, 7, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0001, 7, 10'h0FF, 8, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 0, 4'b0100, 8, 10'h1FF, 9, 1'b0);
`endif

    model_reset();
    do_reset();

    foreach (vt[n]) begin
      if (vt[n].do_rst) do_reset();
      step(vt[n].rq, vt[n].rv, vt[n].rs);
      chk("tbl_grant", 32'(grant), 32'(vt[n].g));
      chk("tbl_gslot", 32'(grant_slot), 32'(vt[n].gs));
      chk("tbl_busy", 32'(slot_busy), 32'(vt[n].busy));
      chk("tbl_nbusy", 32'(n_busy), 32'(vt[n].nb));
      chk("tbl_full", 32'(full), 32'(vt[n].nb == N_SLOTS));
      chk("tbl_err", 32'(err_release), 32'(vt[n].err));
    end

    // Reset asserted between clock edges while a grant and the error flag are live.
    do_reset();
    step(4'b1111, 1'b1, 7);
    chk("pre_rst_gvalid", 32'(grant_valid), 32'd1);
    chk("pre_rst_err", 32'(err_release), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk_100mhz);
    rst = 1'b0;
    model_reset();
    #2;

    // Random traffic: requests held until granted, releases mostly of live slots.
    pend = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (pend[i] && grant[i]) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(3) == 0) pend[i] = 1'b1;
      end
      rv = ($urandom_range(2) == 0);
      busy_list.delete();
      for (int i = 0; i < N_SLOTS; i++) if (m_busy[i]) busy_list.push_back(i);
      if ($urandom_range(9) == 0 || busy_list.size() == 0) rs = int'($urandom_range(15));
      else rs = busy_list[$urandom_range(busy_list.size() - 1)];
      step(pend, rv, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
